rho_inv_seq: RTL
================

RHO_INV_SEQ -- requirements
Module: rho_inv_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  state_in holds a valid 1600-bit state.
REQ-004 in_ready  output  1  block can accept a state this cycle.
REQ-005 state_in  input  1600  post-rho state; lane k=5x+y occupies bits [1599-64k -: 64].
REQ-006 out_valid  output  1  state_out holds the finished inverse-rho result.
REQ-007 out_ready  input  1  consumer accepts state_out this cycle.
REQ-008 state_out  output  1600  inverse-rho result; same lane layout as state_in.
REQ-009 busy  output  1  high in PROC and DONE.
REQ-010 chk_err  output  1  self-check mismatch flag (see Configuration).

Function
REQ-011 The block SHALL compute inverse rho: output lane k = input lane k rotated right by R[k], with R[0..24] = 0,36,3,41,18,1,44,10,45,2,62,6,43,15,61,28,55,25,21,56,27,20,39,8,14.
REQ-012 The FSM SHALL have states IDLE, PROC and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&&in_ready, capture state_in into an input buffer, clear lane counter to 0, go to PROC.
REQ-014 PROC: in_ready=0; each cycle, rotate lane[cnt] with one shared 64-bit rotator, write it to the output buffer, increment cnt; on cnt==24, go to DONE.
REQ-015 DONE: out_valid=1 and state_out stable; on out_ready, go to IDLE in the next cycle.
REQ-016 Latency: out_valid SHALL rise exactly 26 cycles after the accept edge (25 PROC cycles plus 1 DONE-entry cycle).
REQ-017 in_ready SHALL be 0 in PROC and DONE; no accept-while-draining; throughput is 1 state per 27 cycles minimum.
REQ-018 in_valid while busy SHALL be ignored; the captured state SHALL NOT change.
REQ-019 out_ready outside DONE SHALL have no effect; out_valid held with out_ready=0 SHALL keep state_out unchanged indefinitely.
REQ-020 R[k]=0 (lane 0) SHALL pass through unchanged; rotation amount is 6 bits, rotate modulo 64.
REQ-021 The lane counter is 5 bits and SHALL never exceed 24.

Reset
REQ-022 On rst: state IDLE, cnt=0, in_ready=1, out_valid=0, busy=0, chk_err=0, state_out=0.
REQ-023 rst mid-PROC or mid-DONE SHALL abort the job; the partial result is discarded and out_valid is never raised for it.
REQ-024 rst has priority over every handshake in the same cycle.

Configuration
REQ-025 Macro RHO_INV_CHECK_EN: when defined, each PROC cycle the result lane is rotated left by R[cnt] through a second rotator and compared with the captured input lane; chk_err goes high on any mismatch and is sticky until the next accept or rst.
REQ-026 Without RHO_INV_CHECK_EN, the port chk_err is present and tied to 0, and no check logic is instantiated.

Structure
REQ-027 Shared package keccak_pkg SHALL hold LANE_W=64, NUM_LANES=25, the rho offset table R[0..24], and the lane-slice helper (k -> bit offset 1599-64k).
REQ-028 One sub-module, lane_rotr64 (64-bit combinational rotate-right by a 6-bit amount), SHALL be instantiated once for the datapath and once for the check path (left rotate as 64-amount).

Verification
REQ-029 Lane 5 (bits [1279:1216]) = 0x0000000000000001, others 0 -> out lane 5 = 0x8000000000000000, out_valid exactly 26 cycles after accept.
REQ-030 Lane 1 = 0x0000000000000001 -> out lane 1 = 0x0000000010000000; lane 0 = 0xDEADBEEFCAFEF00D -> out lane 0 unchanged.
REQ-031 Random state S fed through the forward rho model, then through the DUT -> state_out == S; with RHO_INV_CHECK_EN, chk_err stays 0.
REQ-032 Hold out_ready=0 for 10 cycles in DONE, and pulse in_valid during that time -> out_valid, state_out and in_ready=0 stay stable; the next state is accepted only after the out_ready handshake.
REQ-033 Assert rst at PROC cnt=12 -> next cycle IDLE, in_ready=1, out_valid=0; a new accept then yields the correct result with 26-cycle latency.
REQ-034 With RHO_INV_CHECK_EN, force an output-buffer bit flip in simulation -> chk_err=1 and stays 1 until the next accept.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak definitions for the inverse-rho sequencer: lane geometry,
// rho offset table, FSM state type and lane-slice helpers.
// Optional self-check in rho_inv_seq is enabled by defining RHO_INV_CHECK_EN.
package keccak_pkg;

    localparam int unsigned LANE_W    = 64;
    localparam int unsigned NUM_LANES = 25;
    localparam int unsigned STATE_W   = LANE_W * NUM_LANES;

    // Rho rotation offsets, indexed by lane k = 5x+y
    localparam logic [5:0] RHO_R [NUM_LANES] = '{
        6'd0,  6'd36, 6'd3,  6'd41, 6'd18,
        6'd1,  6'd44, 6'd10, 6'd45, 6'd2,
        6'd62, 6'd6,  6'd43, 6'd15, 6'd61,
        6'd28, 6'd55, 6'd25, 6'd21, 6'd56,
        6'd27, 6'd20, 6'd39, 6'd8,  6'd14
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } rho_state_t;

    // Most significant bit position of lane k inside the 1600-bit state
    function automatic int unsigned lane_msb(input logic [4:0] k);
        return (STATE_W - 1) - LANE_W * 32'(k);
    endfunction

    // Extract lane k from a full state vector
    function automatic logic [LANE_W-1:0] lane_get(input logic [STATE_W-1:0] s,
                                                   input logic [4:0]         k);
        return s[lane_msb(k) -: LANE_W];
    endfunction

    // Rotation offset for lane k; out-of-range indices map to no rotation
    function automatic logic [5:0] rho_off(input logic [4:0] k);
        return (32'(k) < NUM_LANES) ? RHO_R[k] : 6'd0;
    endfunction

endpackage

// File: rtl/lane_rotr64.sv
// 64-bit combinational rotate-right by a 6-bit amount (modulo 64).
// Used for the inverse-rho datapath and, with RHO_INV_CHECK_EN, for the
// left-rotate check path (left by r == right by 64-r).
module lane_rotr64
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0] lane_i,
    input  logic [5:0]        amt_i,
    output logic [LANE_W-1:0] lane_o
);

    // Amount 0 makes the left shift a full-width shift, which yields zero
    always_comb begin
        lane_o = (lane_i >> amt_i) | (lane_i << (7'd64 - {1'b0, amt_i}));
    end

endmodule

// File: rtl/rho_inv_seq.sv
// Sequential inverse-rho: one lane per cycle through a single shared rotator.
// IDLE accepts a state, PROC rotates lanes 0..24, DONE presents the result
// until out_ready. Defining RHO_INV_CHECK_EN adds a rotate-back self-check
// that drives a sticky chk_err; otherwise chk_err is tied low.
module rho_inv_seq
    import keccak_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy,
    output logic               chk_err
);

    rho_state_t         state_q;
    logic [4:0]         cnt_q;
    logic [4:0]         cnt_d;
    logic [STATE_W-1:0] in_buf_q;
    logic [STATE_W-1:0] out_buf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [LANE_W-1:0]  cur_lane;
    logic [5:0]         cur_amt;
    logic [LANE_W-1:0]  rot_lane;
    logic               accept;

    // Select the lane under process and its rotation amount; saturate counter at 24
    always_comb begin
        cur_lane = lane_get(in_buf_q, cnt_q);
        cur_amt  = rho_off(cnt_q);
        accept   = (state_q == S_IDLE) && in_valid && in_ready_q;
        cnt_d    = (cnt_q == 5'd24) ? cnt_q : cnt_q + 5'd1;
    end

    lane_rotr64 u_rot (
        .lane_i (cur_lane),
        .amt_i  (cur_amt),
        .lane_o (rot_lane)
    );

    // Control FSM with registered handshake outputs and the lane buffers.
    // DONE is entered with out_valid low; it rises on the following edge,
    // giving 25 PROC cycles plus one DONE-entry cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_buf_q    <= '0;
            out_buf_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        in_buf_q   <= state_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_PROC;
                    end
                end
                S_PROC: begin
                    out_buf_q[lane_msb(cnt_q) -: LANE_W] <= rot_lane;
                    cnt_q <= cnt_d;
                    if (cnt_q == 5'd24) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = out_buf_q;

`ifdef RHO_INV_CHECK_EN
    logic              chk_en;
    logic [4:0]        chk_idx;
    logic [LANE_W-1:0] chk_lane;
    logic [5:0]        chk_amt;
    logic [LANE_W-1:0] chk_back;
    logic              chk_err_q;
    logic              chk_err_d;

    // The check reads back the output buffer one cycle after each write
    // (lane cnt-1 during PROC, lane 24 in the DONE-entry cycle) so that
    // corruption of the stored result is caught, not just of the rotator.
    always_comb begin
        chk_en  = 1'b0;
        chk_idx = cnt_q;
        if (state_q == S_PROC && cnt_q != 5'd0) begin
            chk_en  = 1'b1;
            chk_idx = cnt_q - 5'd1;
        end else if (state_q == S_DONE && !out_valid_q) begin
            chk_en  = 1'b1;
            chk_idx = cnt_q;
        end
        chk_lane  = lane_get(out_buf_q, chk_idx);
        chk_amt   = 6'd0 - rho_off(chk_idx);
        chk_err_d = chk_err_q;
        if (accept) begin
            chk_err_d = 1'b0;
        end else if (chk_en && (chk_back != lane_get(in_buf_q, chk_idx))) begin
            chk_err_d = 1'b1;
        end
    end

    lane_rotr64 u_chk_rot (
        .lane_i (chk_lane),
        .amt_i  (chk_amt),
        .lane_o (chk_back)
    );

    // Sticky mismatch flag, cleared by reset or a new accept
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
